// File: rtl/video_pkg.sv
// Shared video/ZBT definitions for the NTSC frame store: pixel type, bus widths and the
// address packing used by both the capture writer and the display reader.
package video_pkg;

  localparam int unsigned ZbtAddrW = 19;
  localparam int unsigned ZbtDataW = 36;

  typedef logic [17:0]          rgb666_t;
  typedef logic [ZbtAddrW-1:0]  zbt_addr_t;
  typedef logic [ZbtDataW-1:0]  zbt_data_t;

  // sw=0: two pixels per word, 512 words per line; sw=1: one pixel per word, 256 per line.
  function automatic zbt_addr_t compose_addr(input logic sw, input logic [9:0] rx,
                                             input logic [9:0] ry);
    if (sw) begin
      return {1'b0, ry[9:1], ry[0], rx[7:0]};
    end
    return {ry[9:1], ry[0], rx[9:1]};
  endfunction

endpackage

// File: rtl/delay_line.sv
// Fixed-depth shift register with a configurable synchronous reset value.
module delay_line #(
  parameter int unsigned      WIDTH     = 1,
  parameter int unsigned      DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_stage [DEPTH];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_stage[i] <= RESET_VAL;
      end
    end else begin
      r_stage[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_q = r_stage[DEPTH-1];

endmodule

// File: rtl/zbt_pixel_reader.sv
// Display-side frame store reader: raster position to ZBT read address, then unpacks the
// returned words into RGB666 pixels with sync/blank delayed to match.
module zbt_pixel_reader
  import video_pkg::*;
#(
  parameter logic [10:0] H_ORIGIN   = 11'd0,
  parameter logic [9:0]  V_ORIGIN   = 10'd0,
  parameter logic [10:0] IMG_W      = 11'd720,
  parameter logic [9:0]  IMG_H      = 10'd480,
  parameter int unsigned RD_LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        sw,
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        blank,
  input  logic [35:0] vram_read_data,
  output logic [18:0] vram_addr,
  output logic [17:0] pixel,
  output logic        phsync,
  output logic        pvsync,
  output logic        pblank
);

  localparam int unsigned Lat = RD_LATENCY + 2;

  logic [10:0] w_rx;
  logic [10:0] w_ry;
  logic        w_inside;
  logic        w_tag_inside;
  logic        w_tag_rx0;
  logic        w_tag_sw;
  rgb666_t     w_sel;

  zbt_addr_t   r_vram_addr;
  rgb666_t     r_pixel;
  rgb666_t     r_word_buf;

  assign w_rx = hcount - H_ORIGIN;
  assign w_ry = {1'b0, vcount} - {1'b0, V_ORIGIN};

  assign w_inside = (hcount >= H_ORIGIN) & (w_rx < IMG_W) & (vcount >= V_ORIGIN) &
                    (w_ry < {1'b0, IMG_H}) & ~blank;

  // Address is frozen outside the image so the ZBT bus stays quiet during blanking.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_vram_addr <= '0;
    end else if (w_inside) begin
      r_vram_addr <= compose_addr(sw, w_rx[9:0], w_ry[9:0]);
    end
  end

  assign vram_addr = r_vram_addr;

  // Tag travels one stage for the address register plus the ZBT read latency.
  delay_line #(
    .WIDTH     (3),
    .DEPTH     (RD_LATENCY + 1),
    .RESET_VAL (3'b000)
  ) u_tag_pipe (
    .clk     (clk),
    .reset_n (reset_n),
    .i_d     ({w_inside, w_rx[0], sw}),
    .o_q     ({w_tag_inside, w_tag_rx0, w_tag_sw})
  );

  delay_line #(
    .WIDTH     (3),
    .DEPTH     (Lat),
    .RESET_VAL (3'b111)
  ) u_sync_pipe (
    .clk     (clk),
    .reset_n (reset_n),
    .i_d     ({hsync, vsync, blank}),
    .o_q     ({phsync, pvsync, pblank})
  );

  always_comb begin
    w_sel = vram_read_data[35:18];
    if (w_tag_sw) begin
      w_sel = vram_read_data[17:0];
    end else if (w_tag_rx0) begin
      w_sel = r_word_buf;
    end
  end

  // Only the right half of a pair word is needed later; the left half is used live.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_pixel    <= '0;
      r_word_buf <= '0;
    end else begin
      if (!w_tag_rx0 || w_tag_sw) begin
        r_word_buf <= vram_read_data[17:0];
      end
      if (w_tag_inside) begin
        r_pixel <= w_sel;
      end else begin
        r_pixel <= '0;
      end
    end
  end

  assign pixel = r_pixel;

endmodule

// File: tb/tb_zbt_pixel_reader.sv
// Scoreboard bench: four readers (read latency 1..4) share one raster stimulus, each with
// its own model ZBT; expectations are queued at sampling time and popped L cycles later.
module tb_zbt_pixel_reader;

  localparam logic [10:0] HOrg = 11'd100;
  localparam logic [18:0] PreAddr = {9'd5, 1'b1, 9'd10};
  localparam logic [35:0] PreWord = {18'h3F000, 18'h00FFF};

  typedef struct {
    int          due;
    logic [17:0] pix;
    logic [2:0]  sync;
  } exp_t;

  logic        clk;
  logic        reset_n;
  logic        sw;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        hsync;
  logic        vsync;
  logic        blank;

  int n_compared;
  int n_mismatched;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [35:0] act, input logic [35:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [35:0] zbt_word(input logic [18:0] a);
    if (a == PreAddr) return PreWord;
    return {a[17:0] ^ 18'h2A5A5, a[18:1] ^ 18'h15555};
  endfunction

  function automatic logic is_inside(input logic [10:0] hc, input logic [9:0] vc,
                                     input logic bl);
    logic [10:0] rx;
    rx = hc - HOrg;
    return (hc >= HOrg) && (rx < 11'd720) && (vc < 10'd480) && !bl;
  endfunction

  function automatic logic [18:0] addr_of(input logic s, input logic [10:0] hc,
                                          input logic [9:0] vc);
    logic [10:0] rx;
    rx = hc - HOrg;
    if (s) return {1'b0, vc, rx[7:0]};
    return {vc, rx[9:1]};
  endfunction

  function automatic logic [17:0] exp_pix(input logic s, input logic [10:0] hc,
                                          input logic [9:0] vc, input logic bl);
    logic [35:0] w;
    logic [10:0] rx;
    if (!is_inside(hc, vc, bl)) return 18'd0;
    rx = hc - HOrg;
    w  = zbt_word(addr_of(s, hc, vc));
    if (s || rx[0]) return w[17:0];
    return w[35:18];
  endfunction

  for (genvar k = 1; k <= 4; k++) begin : g_lat
    localparam int L = k + 2;

    logic [18:0] addr;
    logic [35:0] rdata;
    logic [17:0] pix;
    logic        ph;
    logic        pv;
    logic        pb;
    logic [18:0] pipe [k];
    logic [18:0] exp_addr;
    exp_t        q[$];
    int          ecnt;

    zbt_pixel_reader #(
      .H_ORIGIN   (HOrg),
      .V_ORIGIN   (10'd0),
      .IMG_W      (11'd720),
      .IMG_H      (10'd480),
      .RD_LATENCY (k)
    ) u_dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .sw             (sw),
      .hcount         (hcount),
      .vcount         (vcount),
      .hsync          (hsync),
      .vsync          (vsync),
      .blank          (blank),
      .vram_read_data (rdata),
      .vram_addr      (addr),
      .pixel          (pix),
      .phsync         (ph),
      .pvsync         (pv),
      .pblank         (pb)
    );

    assign rdata = zbt_word(pipe[k-1]);

    // Model ZBT: data for the registered address appears k cycles later.
    initial begin
      for (int i = 0; i < k; i++) pipe[i] = '0;
      forever begin
        @(posedge clk);
        pipe[0] <= addr;
        for (int i = 1; i < k; i++) pipe[i] <= pipe[i-1];
      end
    end

    initial begin
      exp_t e;
      ecnt     = 0;
      exp_addr = '0;
      forever begin
        @(posedge clk);
        ecnt++;
        if (!reset_n) begin
          foreach (q[i]) begin
            q[i].pix  = 18'd0;
            q[i].sync = 3'b111;
          end
          e.pix    = 18'd0;
          e.sync   = 3'b111;
          exp_addr = '0;
        end else begin
          e.pix  = exp_pix(sw, hcount, vcount, blank);
          e.sync = {hsync, vsync, blank};
          if (is_inside(hcount, vcount, blank)) exp_addr = addr_of(sw, hcount, vcount);
        end
        e.due = ecnt + L - 1;
        q.push_back(e);
      end
    end

    initial begin
      exp_t e;
      forever begin
        @(negedge clk);
        check($sformatf("addr L%0d", L), {17'd0, addr}, {17'd0, exp_addr});
        while (q.size() > 0 && q[0].due <= ecnt) begin
          e = q.pop_front();
          check($sformatf("pixel L%0d", L), {18'd0, pix}, {18'd0, e.pix});
          check($sformatf("sync L%0d", L), {33'd0, ph, pv, pb}, {33'd0, e.sync});
        end
      end
    end
  end

  task automatic drive(input logic s, input logic [9:0] vc, input logic [10:0] hc0,
                       input int n, input logic bl);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sw     = s;
      vcount = vc;
      hcount = hc0 + 11'(i);
      blank  = bl;
      hsync  = ~(hcount[2:0] == 3'd5);
      vsync  = ~(hcount[3:0] == 4'd9);
    end
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    reset_n = 1'b0;
    sw      = 1'b0;
    hcount  = 11'd0;
    vcount  = 10'd0;
    hsync   = 1'b1;
    vsync   = 1'b1;
    blank   = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    drive(1'b0, 10'd11, 11'd118, 6, 1'b0);   // rx 18..23, includes preloaded pair at rx 20/21
    drive(1'b0, 10'd11, 11'd96, 8, 1'b0);    // left window edge
    drive(1'b0, 10'd11, 11'd816, 8, 1'b0);   // right window edge
    drive(1'b1, 10'd3, 11'd608, 7, 1'b0);    // alternate layout, rx 0x1FC..0x202
    drive(1'b0, 10'd20, 11'd200, 4, 1'b0);
    drive(1'b0, 10'd20, 11'd204, 2, 1'b1);   // blank inside the window
    drive(1'b0, 10'd20, 11'd206, 6, 1'b0);
    drive(1'b0, 10'd30, 11'd300, 6, 1'b0);

    @(negedge clk);
    reset_n = 1'b0;
    hcount  = 11'd306;
    @(negedge clk);
    reset_n = 1'b1;
    drive(1'b0, 10'd30, 11'd306, 10, 1'b0);

    drive(1'b0, 10'd0, 11'd0, 12, 1'b1);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
